// File: rtl/isa.sv
// Shared ISA-level types for the data-memory path: access sizes, responder
// FSM states and byte-lane helpers. The responder's cache is enabled by
// defining DMEM_CACHE_EN.
package isa;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } mem_access_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dmem_state_t;

  // Byte lane of the access after forcing natural alignment
  function automatic logic [1:0] align_offset(input mem_access_t access,
                                              input logic [1:0]  offset);
    case (access)
      BYTE:      return offset;
      HALF_WORD: return {offset[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  // Byte enables of a naturally aligned access within its word
  function automatic logic [3:0] get_byte_enable(input mem_access_t access,
                                                 input logic [1:0]  offset);
    logic [1:0] lane;
    lane = align_offset(access, offset);
    case (access)
      BYTE:      return 4'b0001 << lane;
      HALF_WORD: return 4'b0011 << lane;
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store shift and byte enables, load shift and size mask.
module dmem_lane_align
  import isa::*;
(
  input  mem_access_t      access,
  input  logic [1:0]       offset,
  input  logic [XLEN-1:0]  wr_data,
  input  logic [XLEN-1:0]  rd_word,
  output logic [3:0]       be,
  output logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  ld_data
);

  logic [1:0]      lane;
  logic [4:0]      shamt;
  logic [XLEN-1:0] shifted;

  // Steer store data up to its lane and bring load data down to bit 0
  always_comb begin
    lane    = align_offset(access, offset);
    shamt   = {lane, 3'b000};
    be      = get_byte_enable(access, offset);
    wdata   = wr_data << shamt;
    shifted = rd_word >> shamt;
    case (access)
      BYTE:      ld_data = XLEN'(shifted[7:0]);
      HALF_WORD: ld_data = XLEN'(shifted[15:0]);
      default:   ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: direct-mapped write-through, no-write-allocate cache
// of one-word lines in front of a req/ack word bus. Define DMEM_CACHE_EN to
// build the cache; without it every access goes to the bus.
module dmem_responder
  import isa::*;
#(
  parameter int unsigned LINES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_enable,
  input  logic              wr_enable,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wr_data,
  input  mem_access_t       wr_access_type,
  output logic              miss,
  output logic [XLEN-1:0]   rd_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [XLEN-1:0]   bus_rdata
);

  dmem_state_t     state, next_state;
  logic            hit;
  logic [XLEN-1:0] cache_word;
  logic [XLEN-1:0] align_word;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_be;
  logic [XLEN-1:0] done_data;

  // Extract from the incoming bus word during a fill, else from the cache
  assign align_word = (state == FILL) ? bus_rdata : cache_word;

  dmem_lane_align u_align (
    .access  (wr_access_type),
    .offset  (addr[1:0]),
    .wr_data (wr_data),
    .rd_word (align_word),
    .be      (st_be),
    .wdata   (st_wdata),
    .ld_data (ld_data)
  );

`ifdef DMEM_CACHE_EN
  localparam int unsigned IDX   = $clog2(LINES);
  localparam int unsigned TAG_W = XLEN - 2 - IDX;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [XLEN-1:0]  words [LINES];
  logic [IDX-1:0]   idx;
  logic [TAG_W-1:0] tag;
  logic [XLEN-1:0]  st_mask;

  assign idx        = addr[2 +: IDX];
  assign tag        = addr[XLEN-1 -: TAG_W];
  assign hit        = valid[idx] && (tags[idx] == tag);
  assign cache_word = words[idx];

  // Expand byte enables to a bit mask for the store-hit merge
  always_comb begin
    for (int i = 0; i < 4; i++) st_mask[8*i +: 8] = {8{st_be[i]}};
  end

  // Valid bits: cleared by reset, set when a fill completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= '0;
    else if (state == FILL && bus_ack) valid[idx] <= 1'b1;
  end

  // Tag/data: install on fill, merge enabled bytes on a store hit
  always_ff @(posedge clk) begin
    if (state == FILL && bus_ack) begin
      tags[idx]  <= tag;
      words[idx] <= bus_rdata;
    end else if (state == WRITE && bus_ack && hit) begin
      words[idx] <= (cache_word & ~st_mask) | (st_wdata & st_mask);
    end
  end
`else
  assign hit        = 1'b0;
  assign cache_word = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Load result of a completed fill, returned in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       done_data <= '0;
    else if (state == FILL && bus_ack) done_data <= ld_data;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (wr_enable)            next_state = WRITE;
        else if (rd_enable && !hit) next_state = FILL;
      end
      FILL:    if (bus_ack) next_state = DONE;
      WRITE:   if (bus_ack) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stall, load data and bus drive for the current state
  always_comb begin
    miss      = 1'b0;
    rd_data   = '0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = 4'h0;
    case (state)
      IDLE: begin
        if (wr_enable) begin
          miss = 1'b1;
        end else if (rd_enable) begin
          if (hit) rd_data = ld_data;
          else     miss    = 1'b1;
        end
      end
      FILL: begin
        miss     = 1'b1;
        bus_req  = 1'b1;
        bus_addr = {addr[XLEN-1:2], 2'b00};
        bus_be   = 4'hF;
      end
      WRITE: begin
        miss      = 1'b1;
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = {addr[XLEN-1:2], 2'b00};
        bus_wdata = st_wdata;
        bus_be    = st_be;
      end
      DONE: begin
        if (rd_enable) rd_data = done_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder; expectations follow DMEM_CACHE_EN.
module tb_dmem_responder;
  import isa::*;

`ifdef DMEM_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rd_enable;
  logic              wr_enable;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wr_data;
  mem_access_t       wr_access_type;
  logic              miss;
  logic [XLEN-1:0]   rd_data;
  logic              bus_req;
  logic              bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic [XLEN-1:0]   bus_rdata;

  int n_vec = 0;
  int n_err = 0;

  dmem_responder #(.LINES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_enable      (rd_enable),
    .wr_enable      (wr_enable),
    .addr           (addr),
    .wr_data        (wr_data),
    .wr_access_type (wr_access_type),
    .miss           (miss),
    .rd_data        (rd_data),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_be         (bus_be),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access: bus answers on the (lat+1)-th request cycle with 'word'
  task automatic access(input string name, input bit st, input logic [31:0] a,
                        input mem_access_t t, input logic [31:0] wd,
                        input logic [31:0] word, input int lat,
                        input int exp_miss, input logic [31:0] exp_rd,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata);
    int          nmiss;
    int          nreq;
    logic        we_c;
    logic [31:0] addr_c;
    logic [31:0] wdata_c;
    logic [3:0]  be_c;
    logic [31:0] rd;
    @(negedge clk);
    rd_enable      = !st;
    wr_enable      = st;
    addr           = a;
    wr_access_type = t;
    wr_data        = wd;
    nmiss = 0; nreq = 0; we_c = 1'b0; addr_c = '0; wdata_c = '0; be_c = '0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (!miss) break;
      nmiss++;
      if (bus_req) begin
        nreq++;
        if (nreq == 1) begin
          we_c = bus_we; addr_c = bus_addr; be_c = bus_be; wdata_c = bus_wdata;
        end
        if (nreq == lat + 1) begin
          bus_ack   = 1'b1;
          bus_rdata = word;
        end
      end
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = '0;
      #1;
    end
    rd = rd_data;
    check({name, ".miss_cycles"}, 32'(nmiss), 32'(exp_miss));
    check({name, ".rd_data"}, rd, exp_rd);
    check({name, ".req_cycles"}, 32'(nreq), (exp_miss == 0) ? 32'(0) : 32'(lat + 1));
    if (nreq != 0) begin
      check({name, ".bus_we"}, 32'(we_c), 32'(st));
      check({name, ".bus_addr"}, addr_c, exp_addr);
      check({name, ".bus_be"}, 32'(be_c), 32'(exp_be));
      if (st) check({name, ".bus_wdata"}, wdata_c, exp_wdata);
    end
    @(negedge clk);
    rd_enable = 1'b0;
    wr_enable = 1'b0;
    #1;
    check({name, ".idle_rd"}, rd_data, 32'h0);
    check({name, ".idle_miss_req"}, {30'b0, miss, bus_req}, 32'h0);
  endtask

  initial begin
    rst_n          = 1'b0;
    rd_enable      = 1'b0;
    wr_enable      = 1'b0;
    addr           = '0;
    wr_data        = '0;
    wr_access_type = WORD;
    bus_ack        = 1'b0;
    bus_rdata      = '0;

    // Reset state, then a request while still in reset
    repeat (2) @(negedge clk);
    #1;
    check("rst.miss", 32'(miss), 32'h0);
    check("rst.rd_data", rd_data, 32'h0);
    check("rst.bus_ctl", {26'b0, bus_req, bus_we, bus_be}, 32'h0);
    check("rst.bus_addr", bus_addr, 32'h0);
    check("rst.bus_wdata", bus_wdata, 32'h0);
    rd_enable = 1'b1;
    addr      = 32'h100;
    #1;
    check("rst.req_miss", 32'(miss), 32'h1);
    check("rst.req_bus", {31'b0, bus_req}, 32'h0);
    check("rst.req_addr", bus_addr, 32'h0);
    check("rst.req_rd", rd_data, 32'h0);
    @(negedge clk);
    rd_enable = 1'b0;
    rst_n     = 1'b1;

    //     name           st  addr     type       wr_data       bus word      lat miss                   rd_data        bus_addr  be       bus_wdata
    access("ldw",          0, 32'h100, WORD,      32'h0,        32'hDEADBEEF, 2, 4,                     32'hDEADBEEF, 32'h100, 4'hF,    32'h0);
    access("ldw_rep",      0, 32'h100, WORD,      32'h0,        32'hDEADBEEF, 0, CACHE_EN ? 0 : 2,      32'hDEADBEEF, 32'h100, 4'hF,    32'h0);
    access("ldb_103",      0, 32'h103, BYTE,      32'h0,        32'hDEADBEEF, 0, CACHE_EN ? 0 : 2,      32'h000000DE, 32'h100, 4'hF,    32'h0);
    access("ldh_102",      0, 32'h102, HALF_WORD, 32'h0,        32'hDEADBEEF, 0, CACHE_EN ? 0 : 2,      32'h0000DEAD, 32'h100, 4'hF,    32'h0);
    access("ldh_103",      0, 32'h103, HALF_WORD, 32'h0,        32'hDEADBEEF, 0, CACHE_EN ? 0 : 2,      32'h0000DEAD, 32'h100, 4'hF,    32'h0);
    access("ldb_100",      0, 32'h100, BYTE,      32'h0,        32'hDEADBEEF, 1, CACHE_EN ? 0 : 3,      32'h000000EF, 32'h100, 4'hF,    32'h0);
    access("stb_101",      1, 32'h101, BYTE,      32'h55,       32'h0,        1, 3,                     32'h0,        32'h100, 4'b0010, 32'h00005500);
    access("ldw_merge",    0, 32'h100, WORD,      32'h0,        32'hDEAD55EF, 0, CACHE_EN ? 0 : 2,      32'hDEAD55EF, 32'h100, 4'hF,    32'h0);
    access("sth_103",      1, 32'h103, HALF_WORD, 32'hA1B2C3D4, 32'h0,        1, 3,                     32'h0,        32'h100, 4'b1100, 32'hC3D40000);
    access("ldw_merge2",   0, 32'h100, WORD,      32'h0,        32'hC3D455EF, 0, CACHE_EN ? 0 : 2,      32'hC3D455EF, 32'h100, 4'hF,    32'h0);
    access("stw_200",      1, 32'h200, WORD,      32'h12345678, 32'h0,        0, 2,                     32'h0,        32'h200, 4'hF,    32'h12345678);
    access("ldw_noalloc",  0, 32'h200, WORD,      32'h0,        32'h12345678, 1, 3,                     32'h12345678, 32'h200, 4'hF,    32'h0);
    access("ld_conflict",  0, 32'h140, WORD,      32'h0,        32'hCAFEF00D, 0, 2,                     32'hCAFEF00D, 32'h140, 4'hF,    32'h0);
    access("ld_evicted",   0, 32'h100, WORD,      32'h0,        32'hC3D455EF, 0, 2,                     32'hC3D455EF, 32'h100, 4'hF,    32'h0);
    access("ld_rehit",     0, 32'h100, WORD,      32'h0,        32'hC3D455EF, 0, CACHE_EN ? 0 : 2,      32'hC3D455EF, 32'h100, 4'hF,    32'h0);

    // Reset in the middle of a fill, then acks that must be ignored
    @(negedge clk);
    rd_enable      = 1'b1;
    addr           = 32'h180;
    wr_access_type = WORD;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (bus_req) break;
      @(negedge clk);
      #1;
    end
    check("rf.req_seen", {31'b0, bus_req}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rf.rst_req", {31'b0, bus_req}, 32'h0);
    check("rf.rst_miss", 32'(miss), 32'h1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = '0;
    rst_n     = 1'b1;
    rd_enable = 1'b0;
    #1;
    check("rf.after_rst", {30'b0, miss, bus_req}, 32'h0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = '0;
    #1;
    check("rf.late_ack", {30'b0, miss, bus_req}, 32'h0);
    check("rf.late_rd", rd_data, 32'h0);
    access("rf.refill",    0, 32'h180, WORD,      32'h0,        32'h11223344, 0, 2,                     32'h11223344, 32'h180, 4'hF,    32'h0);
    access("rf.rehit",     0, 32'h180, WORD,      32'h0,        32'h11223344, 0, CACHE_EN ? 0 : 2,      32'h11223344, 32'h180, 4'hF,    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder sitting behind the pipeline's memory stage and answering its load/store requests. It holds a small direct-mapped, write-through, no-write-allocate cache of one-word lines and reaches backing memory over a simple req/ack word bus. While an access is outstanding it holds `miss` high, which stalls the pipeline. It returns load data right-aligned, so the memory stage does sign/zero extension from bit 0.

## Interface
- `LINES`, 16: number of cache lines; power of two, ≥2; `IDX = $clog2(LINES)`.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_enable`  in  1  load request; held stable while `miss`=1.
- `wr_enable`  in  1  store request; never asserted together with `rd_enable`.
- `addr`  in  XLEN  byte address.
- `wr_data`  in  XLEN  store data, right-aligned (byte in [7:0], half in [15:0]).
- `wr_access_type`  in  mem_access_t  BYTE/HALF_WORD/WORD; valid for loads and stores.
- `miss`  out  1  access not complete this cycle; pipeline stalls.
- `rd_data`  out  XLEN  load data, right-aligned, upper bits zero.
- `bus_req`  out  1  backing-memory request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  XLEN  word address; bits [1:0] are 0.
- `bus_wdata`  out  XLEN  lane-steered write data.
- `bus_be`  out  4  byte enables; 4'hF on reads.
- `bus_ack`  in  1  one-cycle completion; `bus_rdata` is valid with it.
- `bus_rdata`  in  XLEN  read word.

## Operation
- Natural alignment is forced: HALF_WORD ignores `addr[0]`, WORD ignores `addr[1:0]`. No misalignment trap.
- Address split: index `addr[2+:IDX]`, tag `addr[XLEN-1:2+IDX]`. Per line: valid bit, tag, data word.
- FSM `dmem_state_t`: IDLE, FILL, WRITE, DONE.
- IDLE with a load hit: `miss`=0, `rd_data` = the hit word shifted right by `8*addr[1:0]` and masked to the access size. State stays IDLE.
- IDLE with a load miss: `miss`=1, next state FILL.
- IDLE with a store: `miss`=1, next state WRITE.
- FILL: `bus_req`=1, `bus_we`=0, `bus_be`=4'hF. On `bus_ack`, install the line (valid=1, tag, data), latch the extracted load data into `done_data`, and go to DONE.
- WRITE: `bus_req`=1, `bus_we`=1. `bus_be` = 4'b0001/0011/1111 shifted left by `addr[1:0]`. `bus_wdata` = `wr_data` shifted left by `8*addr[1:0]`.
  - On a tag hit, the enabled bytes are merged into the cached word on `bus_ack`. A store miss does not allocate.
  - On `bus_ack`, go to DONE.
- DONE: `miss`=0. `rd_data` = `done_data` for a load, 0 for a store. Next state IDLE unconditionally; the still-presented request is not re-issued.
- No request and not in DONE: `rd_data`=0, `miss`=0.

## Timing
- `miss` is combinational from the request, the hit logic and the state. `bus_*` outputs are combinational from the registered state and the request.
- Load hit: 0 added cycles.
- Load miss: 1 (IDLE) + N (FILL until ack, N ≥ 1) + 1 (DONE) cycles.
- Store: 1 + N + 1 cycles.
- `bus_req` rises the cycle after the request is seen, stays high until and including the `bus_ack` cycle, and drops in DONE.
- Reset values: state IDLE, all valid bits 0, `done_data`=0.
  - Under reset, `bus_req`=0, `bus_we`=0, `bus_be`=0, `bus_addr`=0, `bus_wdata`=0 and `rd_data`=0. `miss` still follows the combinational rule; every access misses.
- Reset during FILL/WRITE: the transaction is abandoned and no line is updated. A late `bus_ack` arriving in IDLE is ignored.
- `bus_ack` outside FILL/WRITE is ignored.
- A fill to an index holding another tag overwrites that line.

## Configuration
- `DMEM_CACHE_EN` defined: cache as described above.
- `DMEM_CACHE_EN` undefined: no tag/data/valid storage. Every load takes the FILL path and every access has bus latency. The port list and timing rules are otherwise identical.

## Structure
- `mem_access_t` is already in `isa`. Add `dmem_state_t` and the function `get_byte_enable(mem_access_t, logic [1:0])` to `isa`.
- Sub-module `dmem_lane_align` (combinational) handles store shift/byte-enable generation and load shift/mask. It is used for bus writes, cache merge and load extraction.

## Test plan
- Load WORD at 0x100 after reset with a 2-cycle ack latency, `bus_rdata`=0xDEADBEEF:
  - Expect `miss`=1 for 4 cycles, then DONE with `rd_data`=0xDEADBEEF.
  - Repeating the load gives a 0-cycle hit.
- Load BYTE at 0x103 after that fill -> hit, `rd_data`=0x000000DE. HALF_WORD at 0x102 -> 0x0000DEAD.
- Store BYTE 0x55 at 0x101 -> `bus_be`=4'b0010, `bus_wdata`=0x00005500, `bus_addr`=0x100. A subsequent WORD load hits with 0xDEAD55EF.
- Store WORD to uncached 0x200, then load 0x200 -> the load misses and issues a FILL (no allocate on store).
- Load 0x100, then load 0x140 (same index when `LINES`=16), then load 0x100 -> three fills (conflict eviction).
- Assert `rst_n`=0 mid-FILL, then ack -> no `bus_req` after reset, the line stays invalid, and a reload re-fills.
